// File: rtl/flag_status_reg.sv
// Registered ALU flag generator: live {N,V,C,Z}, saturating overflow counter,
// and optional sticky flags enabled by the FLAG_STICKY_EN macro.
module flag_status_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] resultado,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             cout,
  input  logic [2:0]       operacao,
  input  logic             clr,
  output logic [3:0]       flags,
  output logic             flags_valid,
`ifdef FLAG_STICKY_EN
  output logic [3:0]       sticky,
`endif
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_e;

  logic             n_new;
  logic             v_new;
  logic             c_new;
  logic             z_new;
  logic [3:0]       new_flags;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    n_new = resultado[WIDTH-1];
    z_new = (resultado == '0);
    c_new = 1'b0;
    v_new = 1'b0;
    if (operacao == OP_ADD) begin
      c_new = cout;
      v_new = (a_msb == b_msb) && (n_new != a_msb);
    end else if (operacao == OP_SUB) begin
      c_new = ~cout;
      v_new = (a_msb != b_msb) && (n_new != a_msb);
    end
    new_flags = {n_new, v_new, c_new, z_new};
  end

  // Clear takes effect before the same-cycle sample, so the sample counts from zero.
  always_comb begin
    cnt_base = clr ? '0 : ovf_count;
    cnt_next = cnt_base;
    if (in_valid && v_new && (cnt_base != '1))
      cnt_next = cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags       <= '0;
      flags_valid <= 1'b0;
      ovf_count   <= '0;
    end else begin
      flags_valid <= in_valid;
      if (in_valid)
        flags <= new_flags;
      ovf_count <= cnt_next;
    end
  end

`ifdef FLAG_STICKY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sticky <= '0;
    else
      sticky <= (clr ? 4'b0000 : sticky) | (in_valid ? new_flags : 4'b0000);
  end
`endif

endmodule

// File: tb/tb_flag_status_reg.sv
// Directed self-checking bench for flag_status_reg (8-bit and 16-bit instances).
module tb_flag_status_reg;

  localparam logic [2:0] ADD = 3'b100;
  localparam logic [2:0] SUB = 3'b101;
  localparam logic [2:0] LOG = 3'b010;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] resultado;
  logic       a_msb;
  logic       b_msb;
  logic       cout;
  logic [2:0] operacao;
  logic       clr;
  logic [3:0] flags;
  logic       flags_valid;
  logic [3:0] ovf_count;
`ifdef FLAG_STICKY_EN
  logic [3:0] sticky;
`endif

  logic        in_valid16;
  logic [15:0] resultado16;
  logic        a_msb16;
  logic        b_msb16;
  logic        cout16;
  logic [2:0]  operacao16;
  logic        clr16;
  logic [3:0]  flags16;
  logic        flags_valid16;
  logic [3:0]  ovf_count16;
`ifdef FLAG_STICKY_EN
  logic [3:0]  sticky16;
`endif

  int checks;
  int failures;

  flag_status_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .resultado(resultado),
    .a_msb(a_msb), .b_msb(b_msb), .cout(cout), .operacao(operacao), .clr(clr),
    .flags(flags), .flags_valid(flags_valid),
`ifdef FLAG_STICKY_EN
    .sticky(sticky),
`endif
    .ovf_count(ovf_count)
  );

  flag_status_reg #(.WIDTH(16), .CNT_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .resultado(resultado16),
    .a_msb(a_msb16), .b_msb(b_msb16), .cout(cout16), .operacao(operacao16), .clr(clr16),
    .flags(flags16), .flags_valid(flags_valid16),
`ifdef FLAG_STICKY_EN
    .sticky(sticky16),
`endif
    .ovf_count(ovf_count16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] res,
                       input logic am, input logic bm, input logic co, input logic cl);
    in_valid  = v;
    operacao  = op;
    resultado = res;
    a_msb     = am;
    b_msb     = bm;
    cout      = co;
    clr       = cl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, ADD, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    checks++; if (flags_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", flags_valid); end
    checks++; if (ovf_count !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", ovf_count); end
    tick;
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_hold_flags got=%b exp=0000", flags); end
`ifdef FLAG_STICKY_EN
    checks++; if (sticky !== 4'b0000) begin failures++; $display("FAIL reset_sticky got=%b exp=0000", sticky); end
`endif
    drive(1'b0, LOG, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick;
  endtask

  task automatic test_add_overflow;
    drive(1'b1, ADD, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    checks++; if (flags !== 4'b1100) begin failures++; $display("FAIL add_ovf_flags got=%b exp=1100", flags); end
    checks++; if (flags_valid !== 1'b1) begin failures++; $display("FAIL add_ovf_valid got=%b exp=1", flags_valid); end
    checks++; if (ovf_count !== 4'd1) begin failures++; $display("FAIL add_ovf_cnt got=%0d exp=1", ovf_count); end
    drive(1'b0, SUB, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    tick;
    checks++; if (flags_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", flags_valid); end
    checks++; if (flags !== 4'b1100) begin failures++; $display("FAIL idle_hold got=%b exp=1100", flags); end
    checks++; if (ovf_count !== 4'd1) begin failures++; $display("FAIL idle_cnt got=%0d exp=1", ovf_count); end
  endtask

  task automatic test_sub;
    drive(1'b1, SUB, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    checks++; if (flags !== 4'b0001) begin failures++; $display("FAIL sub_zero got=%b exp=0001", flags); end
    drive(1'b1, SUB, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    checks++; if (flags !== 4'b0011) begin failures++; $display("FAIL sub_borrow got=%b exp=0011", flags); end
    checks++; if (flags_valid !== 1'b1) begin failures++; $display("FAIL sub_b2b_valid got=%b exp=1", flags_valid); end
    // 0x80 - 0x01 = 0x7F: signed overflow, no borrow
    drive(1'b1, SUB, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0);
    tick;
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL sub_ovf got=%b exp=0100", flags); end
    checks++; if (ovf_count !== 4'd2) begin failures++; $display("FAIL sub_ovf_cnt got=%0d exp=2", ovf_count); end
  endtask

  task automatic test_logic;
    drive(1'b1, LOG, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL logic_flags got=%b exp=1000", flags); end
    drive(1'b1, LOG, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL logic_nz got=%b exp=0000", flags); end
    checks++; if (ovf_count !== 4'd2) begin failures++; $display("FAIL logic_cnt got=%0d exp=2", ovf_count); end
  endtask

  task automatic test_sticky_clear;
    drive(1'b0, LOG, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    checks++; if (ovf_count !== 4'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", ovf_count); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL clr_keeps_flags got=%b exp=0000", flags); end
    checks++; if (flags_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b exp=0", flags_valid); end
    drive(1'b1, ADD, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b1, SUB, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    checks++; if (ovf_count !== 4'd1) begin failures++; $display("FAIL sticky_seq_cnt got=%0d exp=1", ovf_count); end
`ifdef FLAG_STICKY_EN
    checks++; if (sticky !== 4'b1101) begin failures++; $display("FAIL sticky_acc got=%b exp=1101", sticky); end
`endif
    drive(1'b1, LOG, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    checks++; if (ovf_count !== 4'd0) begin failures++; $display("FAIL clr_sample_cnt got=%0d exp=0", ovf_count); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL clr_sample_flags got=%b exp=0000", flags); end
`ifdef FLAG_STICKY_EN
    checks++; if (sticky !== 4'b0000) begin failures++; $display("FAIL clr_sample_sticky got=%b exp=0000", sticky); end
`endif
  endtask

  task automatic test_back_to_back;
    int exp_cnt;
    drive(1'b0, LOG, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, ADD, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
      tick;
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
      checks++; if (ovf_count !== 4'(exp_cnt)) begin failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, ovf_count, exp_cnt); end
      checks++; if (flags_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, flags_valid); end
    end
    drive(1'b1, ADD, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    checks++; if (ovf_count !== 4'd1) begin failures++; $display("FAIL clr_ovf_cnt got=%0d exp=1", ovf_count); end
`ifdef FLAG_STICKY_EN
    checks++; if (sticky !== 4'b1100) begin failures++; $display("FAIL clr_ovf_sticky got=%b exp=1100", sticky); end
`endif
  endtask

  task automatic test_async_reset;
    drive(1'b1, SUB, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b1, ADD, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL mid_rst_flags got=%b exp=0000", flags); end
    checks++; if (flags_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", flags_valid); end
    checks++; if (ovf_count !== 4'd0) begin failures++; $display("FAIL mid_rst_cnt got=%0d exp=0", ovf_count); end
`ifdef FLAG_STICKY_EN
    checks++; if (sticky !== 4'b0000) begin failures++; $display("FAIL mid_rst_sticky got=%b exp=0000", sticky); end
`endif
    tick;
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL rst_discard got=%b exp=0000", flags); end
    rst = 1'b0;
    drive(1'b1, ADD, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    checks++; if (flags !== 4'b1100) begin failures++; $display("FAIL post_rst_flags got=%b exp=1100", flags); end
    checks++; if (flags_valid !== 1'b1) begin failures++; $display("FAIL post_rst_valid got=%b exp=1", flags_valid); end
    checks++; if (ovf_count !== 4'd1) begin failures++; $display("FAIL post_rst_cnt got=%0d exp=1", ovf_count); end
    drive(1'b0, LOG, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_width16;
    // 0xFFFF + 0x0001 = 0x0000 with carry, no signed overflow
    in_valid16 = 1'b1; operacao16 = ADD; resultado16 = 16'h0000;
    a_msb16 = 1'b1; b_msb16 = 1'b0; cout16 = 1'b1; clr16 = 1'b0;
    tick;
    checks++; if (flags16 !== 4'b0011) begin failures++; $display("FAIL w16_zero_carry got=%b exp=0011", flags16); end
    checks++; if (flags_valid16 !== 1'b1) begin failures++; $display("FAIL w16_valid got=%b exp=1", flags_valid16); end
    operacao16 = LOG; resultado16 = 16'h8000; cout16 = 1'b0;
    tick;
    checks++; if (flags16 !== 4'b1000) begin failures++; $display("FAIL w16_neg got=%b exp=1000", flags16); end
    resultado16 = 16'h0100;
    tick;
    checks++; if (flags16 !== 4'b0000) begin failures++; $display("FAIL w16_upper_nz got=%b exp=0000", flags16); end
    in_valid16 = 1'b0;
    tick;
    checks++; if (flags_valid16 !== 1'b0) begin failures++; $display("FAIL w16_idle got=%b exp=0", flags_valid16); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drive(1'b0, LOG, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid16 = 1'b0; operacao16 = LOG; resultado16 = '0;
    a_msb16 = 1'b0; b_msb16 = 1'b0; cout16 = 1'b0; clr16 = 1'b0;
    test_reset;
    test_add_overflow;
    test_sub;
    test_logic;
    test_sticky_clear;
    test_back_to_back;
    test_async_reset;
    test_width16;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_status_reg.md
# flag_status_reg

Registered, width-parametrised successor of the ALU's combinational flag generator. The block samples an ALU result and its operand sign bits on a valid strobe and registers the live flags {Negative, Overflow, Carry, Zero}. It also keeps sticky (accumulated) flags and a saturating overflow-event counter until software clears them. It sits between the ALU datapath and the status/display logic, and gives downstream consumers a stable, clocked status word.

## Interface
- `WIDTH`, default 8: result width in bits, minimum 2.
- `CNT_W`, default 4: overflow-event counter width, minimum 1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: when high, the inputs below are sampled this cycle.
- `resultado` in WIDTH: ALU result.
- `a_msb` in 1: sign bit of operand A.
- `b_msb` in 1: sign bit of operand B.
- `cout` in 1: adder carry-out.
- `operacao` in 3: operation code; 100 = ADD, 101 = SUB, any other code = non-arithmetic.
- `clr` in 1: synchronous clear of the sticky flags and the counter.
- `flags` out 4: live flags {N, V, C, Z}, registered.
- `flags_valid` out 1: one-cycle pulse, high in the cycle after a sample.
- `sticky` out 4: OR-accumulated {N, V, C, Z}. Present only with `FLAG_STICKY_EN`.
- `ovf_count` out CNT_W: saturating count of samples with V = 1.

## Operation
Flag equations, computed on the sampled inputs:
- **Z** = 1 when all WIDTH bits of `resultado` are 0. Z is evaluated for every operation code.
- **N** = `resultado[WIDTH-1]`, for every operation code.
- **C**:
  - ADD: C = `cout`.
  - SUB: C = NOT `cout`, i.e. borrow. This is new behaviour.
  - Other codes: C = 0.
- **V**:
  - ADD: V = (`a_msb` == `b_msb`) AND (`resultado[WIDTH-1]` != `a_msb`).
  - SUB: V = (`a_msb` != `b_msb`) AND (`resultado[WIDTH-1]` != `a_msb`).
  - Other codes: V = 0.

Register updates on each rising edge:
- `in_valid` = 1: `flags` loads the new flag values. Otherwise `flags` holds its value.
- Sticky, with `in_valid` = 1: `sticky` <= `sticky` | new flags.
- Counter, with `in_valid` = 1 and new V = 1: `ovf_count` increments. At all-ones it saturates and holds; it never wraps.
- `clr` = 1: `sticky` and `ovf_count` go to 0. `clr` does not affect `flags` or `flags_valid`.
- `clr` and `in_valid` in the same cycle: the clear is applied first, then the new sample.
  - Result: `sticky` = new flags.
  - Result: `ovf_count` = 1 if new V = 1, otherwise 0.
- Internal state: a counter and a registered valid bit. There is no multi-state FSM.

## Timing
- Reset values, asserted asynchronously: `flags` = 0000, `flags_valid` = 0, `sticky` = 0000, `ovf_count` = 0.
- Latency: inputs sampled at edge k appear on `flags` after edge k. `flags_valid` is high for exactly the cycle following edge k.
- Back-to-back: `in_valid` may be high every cycle. Each sample produces its own `flags_valid` cycle, and no sample is dropped.
- Idle: while `in_valid` = 0, all outputs hold and `flags_valid` = 0.
- Reset mid-stream: outputs go to their reset values immediately. Any sample presented during reset is discarded.
- Reset release: the first sample is accepted at the first rising edge after `rst` deasserts.

## Configuration
- Macro: `FLAG_STICKY_EN`.
- Defined: the `sticky` port and its register exist, with the behaviour given in Operation.
- Undefined: the `sticky` port and its register are removed. `clr` then affects only `ovf_count`. All other behaviour is unchanged.

## Test plan
All scenarios use WIDTH = 8 and CNT_W = 4 unless stated.
- **ADD overflow:** ADD, A = 0x7F, B = 0x01, `resultado` = 0x80, `cout` = 0, a_msb = 0, b_msb = 0.
  - One cycle later: `flags` = {N1, V1, C0, Z0} and `flags_valid` pulses once.
- **SUB, zero result:** SUB, A = 0x05, B = 0x05, `resultado` = 0x00, `cout` = 1.
  - Required: `flags` = {N0, V0, C0, Z1}.
  - Follow-up: the same inputs with `cout` = 0 give C = 1.
- **Logic code:** `operacao` = 010, `resultado` = 0x80, `cout` = 1.
  - Required: `flags` = {N1, V0, C0, Z0}.
- **Sticky, then clear** (with `FLAG_STICKY_EN`): sample the ADD-overflow case, then the SUB-zero case.
  - Required: `sticky` = 1101.
  - Then `clr` together with a logic sample of 0x01: `sticky` = 0000 and `ovf_count` = 0.
- **Counter saturation:** 20 consecutive overflow samples.
  - Required: `ovf_count` reaches 15 and holds at 15.
  - Then `clr` + overflow sample in the same cycle: `ovf_count` = 1.
- **Async reset mid-burst:** assert `rst` between edges during back-to-back samples.
  - Required: all outputs are 0 immediately.
  - After release: the first edge's sample appears on the next cycle.
- **Parametrised width:** WIDTH = 16, ADD, `resultado` = 0x0000, `cout` = 1.
  - Required: Z = 1, C = 1.
